mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed main-memory model that sits on the memory side of the direct-mapped write-back cache. It serves the cache's `mem_req_*` request bus and answers on `mem_res_data` / `mem_res_valid`. Every request completes after a fixed, parameterised latency. The block is the backing store for cache simulation and integration benches.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 10: number of word-index bits. The array holds 2^ADDR_WIDTH 32-bit words (4 KiB at the default).
- `LATENCY`, default 4: cycles from request acceptance to response. Legal range is 1..255.

**Ports**
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `mem_req_addr`  input  32: byte address. Word index is `mem_req_addr[ADDR_WIDTH+1:2]`.
- `mem_req_data`  input  32: write data.
- `mem_req_wen`  input  1: 1 = write, 0 = read.
- `mem_req_valid`  input  1: request present. The initiator holds it and all request fields stable until it sees `mem_res_valid`.
- `mem_res_data`  output  32: read data, or the echoed write data on a write response.
- `mem_res_valid`  output  1: one-cycle completion pulse.
- `mem_busy`  output  1: high while a request is in flight (states WAIT and RESP).
- `mem_res_error`  output  1: present only with `MEM_RESPONDER_RANGE_CHECK_EN` (see Configuration).

## Operation

**FSM states:** IDLE, WAIT, RESP.
- **IDLE:** when `mem_req_valid`=1 at a rising edge, the block:
  - latches addr, data and wen;
  - loads counter with `LATENCY-1`;
  - moves to WAIT.
  - With `mem_req_valid`=0 it stays in IDLE.
- **WAIT:** at each edge, if counter = 0 the block moves to RESP; otherwise counter decrements.
  - On the WAIT->RESP edge, a write commits the latched data to the array, and `mem_res_data` is loaded with that data.
  - On the same edge, a read loads `mem_res_data` with `array[index]`.
- **RESP:** `mem_res_valid`=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
  - Request inputs sampled during RESP are ignored.
  - A back-to-back request is accepted at the first edge spent in IDLE.
- The counter is 8 bits wide and never wraps: it is loaded only in IDLE and stops at 0.
- Request inputs are sampled only at acceptance. Changes during WAIT have no effect.
- Address bits [1:0] are ignored (word access only).
- Address bits above `ADDR_WIDTH+1` are ignored, so the address space aliases modulo 2^(ADDR_WIDTH+2) bytes.
- Read-after-write to the same word returns the newly written value.
- The memory array is not affected by `rst` and is zero-initialised at simulation time 0.

## Timing

- **Reset values (`rst`=1, asynchronous):**
  - state = IDLE, counter = 0;
  - `mem_res_data` = 0, `mem_res_valid` = 0, `mem_busy` = 0, `mem_res_error` = 0.
- **Latency:** if a request is accepted at edge E0, `mem_res_valid` is high in the cycle after edge E0+LATENCY. Minimum turnaround per request is LATENCY+2 cycles (accept, LATENCY cycles, one IDLE cycle).
- `mem_busy` rises in the cycle after acceptance and falls in the cycle after RESP.
- `mem_res_data` holds its value after RESP until the next response load.
- **Reset mid-operation:** the pending request is dropped and no response is issued. A write that has not yet reached the WAIT->RESP edge is not committed.
- **Reset released while `mem_req_valid`=1:** the request is accepted at the first rising edge with `rst`=0.

## Configuration

Macro: `MEM_RESPONDER_RANGE_CHECK_EN`.
- **Defined:**
  - The `mem_res_error` port exists.
  - At acceptance, the request is flagged bad if `mem_req_addr[31:ADDR_WIDTH+2]` is nonzero or `mem_req_addr[1:0]` is nonzero.
  - A bad request still completes with normal latency, and `mem_res_error`=1 during its RESP cycle (0 otherwise).
  - A bad write is not committed. A bad read returns `mem_res_data` = 0.
- **Undefined:** the port is absent, there is no checking, and aliasing applies as described in Operation.

## Test plan

- **Reset:** assert `rst` mid-WAIT of a write of 0xDEADBEEF to 0x10, then read 0x10. Required: no `mem_res_valid` pulse for the aborted write; the read returns 0x00000000; all outputs are 0 during reset.
- **Read latency, LATENCY=4:** write 0x12345678 to 0x40, then read 0x40. Required: `mem_res_valid` high exactly 4 cycles after the accept edge, for 1 cycle, with `mem_res_data`=0x12345678.
- **Back-to-back:** hold `mem_req_valid`=1 for write 0x1 to addr 0x0, then immediately read 0x0. Required: the second accept happens 1 cycle after the first RESP, and the read returns 0x00000001.
- **LATENCY=1 boundary:** read 0x4. Required: `mem_res_valid` in the cycle after the accept edge. Changing `mem_req_addr` during WAIT does not alter the data returned.
- **Aliasing, macro undefined, ADDR_WIDTH=10:** write 0xA5A5A5A5 to 0x1000, read 0x0000. Required: the read returns 0xA5A5A5A5.
- **Range check, macro defined:** write 0x77 to 0x1000, then read 0x1002, then read 0x0. Required:
  - the write and the 0x1002 read each give `mem_res_error`=1 on their response, with `mem_res_data`=0 for the read;
  - the read of 0x0 returns 0x0 with `mem_res_error`=0.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the cache and mem_responder (MEM_RESPONDER_RANGE_CHECK_EN adds mem_res_error)
interface mem_responder_if;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_req_wen;
    logic        mem_req_valid;
    logic [31:0] mem_res_data;
    logic        mem_res_valid;
    logic        mem_busy;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic        mem_res_error;
`endif

    modport master (
        output mem_req_addr, mem_req_data, mem_req_wen, mem_req_valid,
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        input  mem_res_error,
`endif
        input  mem_res_data, mem_res_valid, mem_busy
    );

    modport slave (
        input  mem_req_addr, mem_req_data, mem_req_wen, mem_req_valid,
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        output mem_res_error,
`endif
        output mem_res_data, mem_res_valid, mem_busy
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory model; MEM_RESPONDER_RANGE_CHECK_EN enables address range/alignment checking
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int          DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              cnt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             wdata;
    logic                    wen;
    logic [31:0]             res_data;
    logic                    accept;
    logic                    finish;
    logic                    commit;
    logic [31:0]             mem [DEPTH] = '{default: 32'h0};

    assign accept = (state == IDLE) && bus.mem_req_valid;
    assign finish = (state == WAIT) && (cnt == 8'd0);

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic bad;
    assign commit            = finish && wen && !bad;
    assign bus.mem_res_error = (state == RESP) && bad;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_req_addr[31:ADDR_WIDTH+2], bus.mem_req_addr[1:0]};
    assign commit           = finish && wen;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.mem_req_valid) state_next = WAIT;
            WAIT:    if (cnt == 8'd0)       state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            idx      <= '0;
            wdata    <= 32'h0;
            wen      <= 1'b0;
            res_data <= 32'h0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
            bad      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                cnt   <= LAT_M1;
                idx   <= bus.mem_req_addr[ADDR_WIDTH+1:2];
                wdata <= bus.mem_req_data;
                wen   <= bus.mem_req_wen;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                bad   <= (|bus.mem_req_addr[31:ADDR_WIDTH+2]) || (|bus.mem_req_addr[1:0]);
`endif
            end else if ((state == WAIT) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
            if (finish) begin
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
                // A rejected read returns zero rather than aliased contents.
                res_data <= wen ? wdata : (bad ? 32'h0 : mem[idx]);
`else
                res_data <= wen ? wdata : mem[idx];
`endif
            end
        end
    end

    // Array has no reset so contents survive rst; reset forces state out of WAIT before any commit.
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= wdata;
    end

    assign bus.mem_res_data  = res_data;
    assign bus.mem_res_valid = (state == RESP);
    assign bus.mem_busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder at LATENCY=4 and LATENCY=1
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus1 ();

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic get_err();
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        return bus.mem_res_error;
`else
        return 1'b0;
`endif
    endfunction

    // Raises valid and returns at the negedge of the response cycle with valid still high.
    // lat counts edges after the first one, so an immediate accept gives LATENCY.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                          output logic [31:0] rd, output int lat, output logic er);
        bus.mem_req_addr  = a;
        bus.mem_req_data  = d;
        bus.mem_req_wen   = w;
        bus.mem_req_valid = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_res_valid) begin
                lat = k - 1;
                break;
            end
        end
        rd = bus.mem_res_data;
        er = get_err();
    endtask

    task automatic do_req1(input logic [31:0] a, input logic [31:0] d, input logic w,
                           output logic [31:0] rd, output int lat);
        bus1.mem_req_addr  = a;
        bus1.mem_req_data  = d;
        bus1.mem_req_wen   = w;
        bus1.mem_req_valid = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.mem_res_valid) begin
                lat = k - 1;
                break;
            end
        end
        rd = bus1.mem_res_data;
        bus1.mem_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_req(input string tag);
        bus.mem_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_valid_one_cycle"}, 32'(bus.mem_res_valid), 32'd0);
        check_eq({tag, "_busy_fall"}, 32'(bus.mem_busy), 32'd0);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        er;
    int          pulses;

    initial begin
        bus.mem_req_addr   = 32'h0;
        bus.mem_req_data   = 32'h0;
        bus.mem_req_wen    = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus1.mem_req_addr  = 32'h0;
        bus1.mem_req_data  = 32'h0;
        bus1.mem_req_wen   = 1'b0;
        bus1.mem_req_valid = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_res_valid", 32'(bus.mem_res_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.mem_busy), 32'd0);
        check_eq("rst_res_data", bus.mem_res_data, 32'h0);
        check_eq("rst_res_error", 32'(get_err()), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Abort a write mid-WAIT with reset.
        bus.mem_req_addr  = 32'h10;
        bus.mem_req_data  = 32'hDEADBEEF;
        bus.mem_req_wen   = 1'b1;
        bus.mem_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("accept_busy", 32'(bus.mem_busy), 32'd1);
        check_eq("accept_no_valid", 32'(bus.mem_res_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus.mem_busy), 32'd0);
        check_eq("midrst_valid", 32'(bus.mem_res_valid), 32'd0);
        check_eq("midrst_data", bus.mem_res_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_res_valid) pulses++;
        end
        check_eq("abort_no_pulse", 32'(pulses), 32'd0);
        do_req(32'h10, 32'h0, 1'b0, rd, lat, er);
        check_eq("abort_read_data", rd, 32'h0);
        end_req("abort_read");

        // Latency and read-after-write.
        do_req(32'h40, 32'h12345678, 1'b1, rd, lat, er);
        check_eq("wr40_lat", 32'(lat), 32'd4);
        check_eq("wr40_echo", rd, 32'h12345678);
        end_req("wr40");
        do_req(32'h40, 32'h0, 1'b0, rd, lat, er);
        check_eq("rd40_lat", 32'(lat), 32'd4);
        check_eq("rd40_data", rd, 32'h12345678);
        end_req("rd40");
        check_eq("rd40_data_hold", bus.mem_res_data, 32'h12345678);

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        do_req(32'h1000, 32'h77, 1'b1, rd, lat, er);
        check_eq("rc_wr_err", 32'(er), 32'd1);
        end_req("rc_wr");
        do_req(32'h1002, 32'h0, 1'b0, rd, lat, er);
        check_eq("rc_rd_err", 32'(er), 32'd1);
        check_eq("rc_rd_data", rd, 32'h0);
        end_req("rc_rd");
        do_req(32'h0, 32'h0, 1'b0, rd, lat, er);
        check_eq("rc_rd0_err", 32'(er), 32'd0);
        check_eq("rc_rd0_data", rd, 32'h0);
        end_req("rc_rd0");
`else
        do_req(32'h1000, 32'hA5A5A5A5, 1'b1, rd, lat, er);
        end_req("alias_wr");
        do_req(32'h0, 32'h0, 1'b0, rd, lat, er);
        check_eq("alias_rd_data", rd, 32'hA5A5A5A5);
        end_req("alias_rd");
`endif

        // Back-to-back: valid held through RESP, so the read is accepted one edge late.
        do_req(32'h0, 32'h1, 1'b1, rd, lat, er);
        check_eq("b2b_wr_lat", 32'(lat), 32'd4);
        do_req(32'h0, 32'h0, 1'b0, rd, lat, er);
        check_eq("b2b_rd_lat", 32'(lat), 32'd5);
        check_eq("b2b_rd_data", rd, 32'h1);
        end_req("b2b_rd");

        // LATENCY=1 instance, with request fields changed during WAIT.
        do_req1(32'h4, 32'hCAFE0004, 1'b1, rd, lat);
        check_eq("l1_wr_lat", 32'(lat), 32'd1);
        bus1.mem_req_addr  = 32'h4;
        bus1.mem_req_wen   = 1'b0;
        bus1.mem_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("l1_wait_no_valid", 32'(bus1.mem_res_valid), 32'd0);
        check_eq("l1_wait_busy", 32'(bus1.mem_busy), 32'd1);
        bus1.mem_req_addr = 32'h8;
        bus1.mem_req_data = 32'h55AA55AA;
        bus1.mem_req_wen  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("l1_rd_valid", 32'(bus1.mem_res_valid), 32'd1);
        check_eq("l1_rd_data", bus1.mem_res_data, 32'hCAFE0004);
        bus1.mem_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        do_req1(32'h8, 32'h0, 1'b0, rd, lat);
        check_eq("l1_rd8_lat", 32'(lat), 32'd1);
        check_eq("l1_rd8_data", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
